// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // RISC-V canonical NOP (addi x0, x0, 0); fetch data presented after reset.
  localparam logic [31:0] NOP_INSN        = 32'h0000_0013;
  localparam int unsigned LATENCY_DEFAULT = 2;
  localparam int unsigned CNT_W           = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// MEM-stage data port. Data requests win ties; one access in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             owner_dm;
  logic             we_q;

  // Byte-offset bits are deliberately ignored: accesses are word-granular.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and strobe/handshake outputs.
  always_comb begin
    state_next = state;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    if_ready_o = 1'b0;
    dm_ready_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req_i || if_req_i) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_o   = 1'b1;
        mem_we_o   = we_q;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if_ready_o = ~owner_dm;
        dm_ready_o = owner_dm;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);
  end

  // Grant latch, latency counter and per-requester read-data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= '0;
      owner_dm    <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= NOP_INSN;
      dm_rdata_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dm_req_i) begin
            owner_dm    <= 1'b1;
            we_q        <= dm_we_i;
            mem_addr_o  <= dm_addr_i[31:2];
            mem_wdata_o <= dm_wdata_i;
          end else if (if_req_i) begin
            owner_dm    <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_o  <= if_addr_i[31:2];
          end
        end
        ISSUE: begin
          cnt <= CNT_W'(LATENCY - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            // Stores pass through the same states but leave read data untouched.
            if (!we_q) begin
              if (owner_dm) begin
                dm_rdata_o <= mem_rdata_i;
              end else begin
                if_rdata_o <= mem_rdata_i;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one LATENCY=2 instance under directed
// and random traffic with a scoreboard, plus LATENCY=1 and LATENCY=7 instances
// for latency checks. A bus-side memory model answers each instance.
module tb_mem_arbiter;

  localparam int TXN_CYC = 12;
  localparam int LAT [3] = '{2, 1, 7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req_v   [3];
  logic [31:0] if_addr_v  [3];
  logic [31:0] if_rdata_v [3];
  logic        if_ready_v [3];
  logic [31:0] dm_rdata_v [3];
  logic        dm_ready_v [3];
  logic        mem_en_v   [3];
  logic        mem_we_v   [3];
  logic [29:0] mem_addr_v [3];
  logic [31:0] mem_wdata_v[3];
  logic [31:0] mem_rdata_v[3];
  logic        stall_v    [3];

  logic        dm_req   = 1'b0;
  logic        dm_we    = 1'b0;
  logic [31:0] dm_addr  = '0;
  logic [31:0] dm_wdata = '0;

  mem_arbiter #(.LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_v[0]), .if_addr_i(if_addr_v[0]), .if_rdata_o(if_rdata_v[0]), .if_ready_o(if_ready_v[0]),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata_v[0]), .dm_ready_o(dm_ready_v[0]),
    .mem_en_o(mem_en_v[0]), .mem_we_o(mem_we_v[0]), .mem_addr_o(mem_addr_v[0]),
    .mem_wdata_o(mem_wdata_v[0]), .mem_rdata_i(mem_rdata_v[0]), .stall_o(stall_v[0])
  );

  mem_arbiter #(.LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_v[1]), .if_addr_i(if_addr_v[1]), .if_rdata_o(if_rdata_v[1]), .if_ready_o(if_ready_v[1]),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
    .dm_rdata_o(dm_rdata_v[1]), .dm_ready_o(dm_ready_v[1]),
    .mem_en_o(mem_en_v[1]), .mem_we_o(mem_we_v[1]), .mem_addr_o(mem_addr_v[1]),
    .mem_wdata_o(mem_wdata_v[1]), .mem_rdata_i(mem_rdata_v[1]), .stall_o(stall_v[1])
  );

  mem_arbiter #(.LATENCY(7)) u_l7 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_v[2]), .if_addr_i(if_addr_v[2]), .if_rdata_o(if_rdata_v[2]), .if_ready_o(if_ready_v[2]),
    .dm_req_i(1'b0), .dm_we_i(1'b0), .dm_addr_i(32'h0), .dm_wdata_i(32'h0),
    .dm_rdata_o(dm_rdata_v[2]), .dm_ready_o(dm_ready_v[2]),
    .mem_en_o(mem_en_v[2]), .mem_we_o(mem_we_v[2]), .mem_addr_o(mem_addr_v[2]),
    .mem_wdata_o(mem_wdata_v[2]), .mem_rdata_i(mem_rdata_v[2]), .stall_o(stall_v[2])
  );

  // ---------------- memory contents ----------------
  logic [31:0] bus_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] bus_read(input logic [29:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Bus model: read data is valid only in the cycle exactly LATENCY after mem_en.
  int          cyc = 0;
  int          en_cyc [3] = '{-100, -100, -100};
  logic [31:0] rd_word[3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_en_v[k]) begin
        en_cyc[k]  <= cyc;
        rd_word[k] <= bus_read(mem_addr_v[k]);
        if (mem_we_v[k]) bus_mem[mem_addr_v[k]] = mem_wdata_v[k];
      end
    end
    cyc <= cyc + 1;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      mem_rdata_v[k] = (cyc == en_cyc[k] + LAT[k]) ? rd_word[k] : 32'hBAD0_BAD0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  // ---------------- scoreboard for the LATENCY=2 instance ----------------
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  logic [31:0] dm_last = 32'h0;
  bit          busy = 1'b0;
  int          en_total = 0;
  int          done_total = 0;
  int          aborted = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en_v[0]) begin
        check_eq("one_in_flight", 32'(busy), 32'h0);
        busy = 1'b1;
        en_total++;
      end
      if (if_ready_v[0]) begin
        busy = 1'b0;
        done_total++;
        if (if_exp.size() == 0) check_eq("if_unexpected_ready", 32'h1, 32'h0);
        else check_eq("if_rdata", if_rdata_v[0], if_exp.pop_front());
      end
      if (dm_ready_v[0]) begin
        busy = 1'b0;
        done_total++;
        if (dm_exp.size() == 0) check_eq("dm_unexpected_ready", 32'h1, 32'h0);
        else check_eq("dm_rdata", dm_rdata_v[0], dm_exp.pop_front());
      end
    end
  end

  // ---------------- transaction driver ----------------
  int          if_done_c, dm_done_c;
  logic [31:0] if_seen, dm_seen;
  int          en_c[$];
  logic [29:0] en_addr[$];
  logic        en_we[$];
  logic [31:0] en_wd[$];
  logic [15:0] stall_mask;

  // Called at a negedge; that cycle is cycle 0 of the transaction.
  task automatic txn(input logic dif, input logic [31:0] ia, input logic ddm, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd, input logic scramble);
    logic [31:0] v;
    if (ddm) begin
      if (dwe) begin
        ref_mem[da[31:2]] = dwd;
        dm_exp.push_back(dm_last);
      end else begin
        v = ref_read(da[31:2]);
        dm_exp.push_back(v);
        dm_last = v;
      end
    end
    if (dif) if_exp.push_back(ref_read(ia[31:2]));
    if_req_v[0] = dif; if_addr_v[0] = ia;
    dm_req = ddm; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    if_done_c = -1; dm_done_c = -1; stall_mask = '0;
    en_c.delete(); en_addr.delete(); en_we.delete(); en_wd.delete();
    for (int c = 0; c < TXN_CYC; c++) begin
      if (c == 0) #1; else @(negedge clk);
      stall_mask[c] = stall_v[0];
      check_eq("stall_formula", 32'(stall_v[0]),
               32'((if_req_v[0] & ~if_ready_v[0]) | (dm_req & ~dm_ready_v[0])));
      if (mem_en_v[0]) begin
        en_c.push_back(c); en_addr.push_back(mem_addr_v[0]);
        en_we.push_back(mem_we_v[0]); en_wd.push_back(mem_wdata_v[0]);
      end
      if (if_ready_v[0]) begin if_done_c = c; if_seen = if_rdata_v[0]; if_req_v[0] = 1'b0; end
      if (dm_ready_v[0]) begin dm_done_c = c; dm_seen = dm_rdata_v[0]; dm_req = 1'b0; end
      if (scramble && c == 2) begin
        if (ddm) begin dm_addr = $urandom; dm_wdata = $urandom; dm_we = ~dwe; end
        else if_addr_v[0] = $urandom;
      end
    end
    if (if_req_v[0]) begin check_eq("if_timeout", 32'h1, 32'h0); if_req_v[0] = 1'b0; end
    if (dm_req)      begin check_eq("dm_timeout", 32'h1, 32'h0); dm_req = 1'b0; end
  endtask

  // IF-only load on instance k; called at a negedge which becomes cycle 0.
  task automatic lat_run(input int k, input logic [31:0] a);
    int          done_c = -1;
    int          nen = 0;
    logic [31:0] got = 32'h0;
    logic [31:0] want;
    want = ref_read(a[31:2]);
    if_req_v[k] = 1'b1; if_addr_v[k] = a;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) #1; else @(negedge clk);
      if (mem_en_v[k]) nen++;
      if (if_ready_v[k]) begin done_c = c; got = if_rdata_v[k]; if_req_v[k] = 1'b0; break; end
    end
    if_req_v[k] = 1'b0;
    check_eq($sformatf("lat%0d_ready_cycle", LAT[k]), 32'(done_c), 32'(LAT[k] + 2));
    check_eq($sformatf("lat%0d_en_count", LAT[k]), 32'(nen), 32'h1);
    check_eq($sformatf("lat%0d_data", LAT[k]), got, want);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic dif, ddm, dwe;
    logic [31:0] ia, da;
    for (int k = 0; k < 3; k++) begin if_req_v[k] = 1'b0; if_addr_v[k] = '0; end
    bus_mem[30'h4002] = 32'hDEAD_BEEF;
    ref_mem[30'h4002] = 32'hDEAD_BEEF;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_mem_en", 32'(mem_en_v[0]), 32'h0);
    check_eq("rst_mem_we", 32'(mem_we_v[0]), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr_v[0]), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata_v[0], 32'h0);
    check_eq("rst_if_ready", 32'(if_ready_v[0]), 32'h0);
    check_eq("rst_dm_ready", 32'(dm_ready_v[0]), 32'h0);
    check_eq("rst_if_rdata", if_rdata_v[0], 32'h0000_0013);
    check_eq("rst_dm_rdata", dm_rdata_v[0], 32'h0);
    check_eq("rst_stall", 32'(stall_v[0]), 32'h0);

    // IF-only load raised in the first cycle after reset release.
    rst = 1'b0;
    txn(1'b1, 32'h0001_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("if_only_en_count", 32'(en_c.size()), 32'h1);
    if (en_c.size() > 0) begin
      check_eq("if_only_en_cycle", 32'(en_c[0]), 32'h1);
      check_eq("if_only_addr", 32'(en_addr[0]), 32'h0000_4002);
      check_eq("if_only_we", 32'(en_we[0]), 32'h0);
    end
    check_eq("if_only_done_cycle", 32'(if_done_c), 32'h4);
    check_eq("if_only_data", if_seen, 32'hDEAD_BEEF);

    // Simultaneous IF and DM load: DM first, IF after DM's DONE.
    @(negedge clk);
    txn(1'b1, 32'h0001_0008, 1'b1, 1'b0, 32'h1000_8000, 32'h0, 1'b0);
    check_eq("both_dm_done", 32'(dm_done_c), 32'h4);
    check_eq("both_if_done", 32'(if_done_c), 32'h9);
    check_eq("both_en_count", 32'(en_c.size()), 32'h2);
    if (en_c.size() == 2) begin
      check_eq("both_dm_en_cycle", 32'(en_c[0]), 32'h1);
      check_eq("both_dm_addr", 32'(en_addr[0]), 32'h0400_2000);
      check_eq("both_if_en_cycle", 32'(en_c[1]), 32'h6);
      check_eq("both_if_addr", 32'(en_addr[1]), 32'h0000_4002);
    end
    check_eq("both_stall_0_3", 32'(stall_mask[3:0]), 32'hF);
    check_eq("both_stall_5_8", 32'(stall_mask[8:5]), 32'hF);
    check_eq("both_stall_9", 32'(stall_mask[9]), 32'h0);

    // Store, then read it back through the data port.
    @(negedge clk);
    txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_8004, 32'h1234_5678, 1'b0);
    check_eq("st_en_count", 32'(en_c.size()), 32'h1);
    if (en_c.size() > 0) begin
      check_eq("st_en_cycle", 32'(en_c[0]), 32'h1);
      check_eq("st_we", 32'(en_we[0]), 32'h1);
      check_eq("st_addr", 32'(en_addr[0]), 32'h0400_2001);
      check_eq("st_wdata", en_wd[0], 32'h1234_5678);
    end
    check_eq("st_done_cycle", 32'(dm_done_c), 32'h4);
    check_eq("st_rdata_kept", dm_seen, init_word(30'h0400_2000));
    @(negedge clk);
    txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_8006, 32'h0, 1'b0);
    check_eq("st_readback", dm_seen, 32'h1234_5678);

    // Reset while the fetch is in WAIT: transaction abandoned.
    @(negedge clk);
    if_req_v[0] = 1'b1; if_addr_v[0] = 32'h0000_0040;
    repeat (2) @(negedge clk);
    rst = 1'b1; if_req_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0; busy = 1'b0; aborted++;
    check_eq("abort_if_rdata", if_rdata_v[0], 32'h0000_0013);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("abort_no_ready", 32'({if_ready_v[0], dm_ready_v[0]}), 32'h0);
      check_eq("abort_no_en", 32'(mem_en_v[0]), 32'h0);
      check_eq("abort_if_rdata_hold", if_rdata_v[0], 32'h0000_0013);
    end
    dm_last = 32'h0;
    @(negedge clk);
    txn(1'b1, 32'h0001_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("rereq_done_cycle", 32'(if_done_c), 32'h4);
    check_eq("rereq_data", if_seen, 32'hDEAD_BEEF);

    // Back-to-back IF loads at LATENCY=1 and LATENCY=7.
    @(negedge clk); lat_run(1, 32'h0000_0100);
    @(negedge clk); lat_run(1, 32'h0001_0009);
    @(negedge clk); lat_run(2, 32'h0000_0204);
    @(negedge clk); lat_run(2, 32'h0001_000B);

    // Random mixed traffic; IF reads a region the data port never writes.
    for (int i = 0; i < 40; i++) begin
      dif = 1'($urandom_range(0, 1));
      ddm = 1'($urandom_range(0, 1));
      if (!dif && !ddm) dif = 1'b1;
      dwe = 1'($urandom_range(0, 1));
      ia  = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      da  = 32'h1000_8000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      @(negedge clk);
      txn(dif, ia, ddm, dwe, da, $urandom, 1'b1);
    end

    repeat (3) @(negedge clk);
    check_eq("if_queue_drained", 32'(if_exp.size()), 32'h0);
    check_eq("dm_queue_drained", 32'(dm_exp.size()), 32'h0);
    check_eq("one_en_per_request", 32'(en_total), 32'(done_total + aborted));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, memory read latency in cycles from the mem_en_o cycle to valid mem_rdata_i (legal 1..7).
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 if_req_i  input  1  instruction-fetch request, held until if_ready_o.
REQ-005 if_addr_i  input  32  fetch byte address.
REQ-006 if_rdata_o  output  32  fetched word, valid while if_ready_o=1.
REQ-007 if_ready_o  output  1  one-cycle completion pulse for fetch.
REQ-008 dm_req_i  input  1  MEM-stage data request, held until dm_ready_o.
REQ-009 dm_we_i  input  1  1=store, 0=load.
REQ-010 dm_addr_i  input  32  data byte address.
REQ-011 dm_wdata_i  input  32  store data.
REQ-012 dm_rdata_o  output  32  load data, valid while dm_ready_o=1.
REQ-013 dm_ready_o  output  1  one-cycle completion pulse for data.
REQ-014 mem_en_o  output  1  single-cycle access strobe to unified single-port memory.
REQ-015 mem_we_o  output  1  write enable, qualified by mem_en_o.
REQ-016 mem_addr_o  output  30  word address (byte address bits 31:2).
REQ-017 mem_wdata_o  output  32  write data.
REQ-018 mem_rdata_i  input  32  read data from memory.
REQ-019 stall_o  output  1  pipeline freeze request to hazard/PC logic.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: at edge with any request pending, latch winner (DM beats IF), its address/we/wdata, go to ISSUE; otherwise stay.
REQ-022 ISSUE: mem_en_o=1 for exactly this cycle with latched mem_we_o/mem_addr_o/mem_wdata_o; load counter with LATENCY-1; go to WAIT.
REQ-023 WAIT: decrement counter; when counter is 0, capture mem_rdata_i into the owner's rdata register and go to DONE.
REQ-024 DONE: assert owner's ready for one cycle; go to IDLE; no request sampled in DONE.
REQ-025 Latency: request first seen in cycle 0 -> ready in cycle LATENCY+2; mem_en_o in cycle 1.
REQ-026 Simultaneous IF and DM requests in IDLE: DM granted; IF granted at the IDLE following DM's DONE.
REQ-027 Stores complete through the same states; dm_rdata_o keeps its previous value on a store.
REQ-028 Address bits 1:0 ignored; no misalignment fault.
REQ-029 Inputs sampled only at the IDLE grant edge; later changes on the latched requester's lines are ignored until DONE.
REQ-030 stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o), combinational.
REQ-031 mem_en_o, mem_we_o = 0 outside ISSUE; at most one access in flight.
REQ-032 if_rdata_o, dm_rdata_o registered and independent; each updates only on its own load completion.

Reset
REQ-033 rst_i=1 at an edge forces IDLE, counter 0, both ready 0, mem_en_o/mem_we_o 0, mem_addr_o/mem_wdata_o 0, if_rdata_o 32'h00000013 (NOP), dm_rdata_o 0.
REQ-034 Reset mid-access (ISSUE/WAIT/DONE) abandons the transaction: no ready pulse, late mem_rdata_i ignored.
REQ-035 First grant possible at the first edge after rst_i deasserts.

Structure
REQ-036 Shared package holds: FSM state encoding, NOP constant 32'h00000013, LATENCY default, counter width 3.
REQ-037 Single module; no sub-module (counter and FSM inline).

Verification
REQ-038 LATENCY=2, IF-only read of 0x00010008, memory word 0xDEADBEEF -> mem_en_o cycle 1, mem_addr_o=0x4002, if_ready_o and if_rdata_o=0xDEADBEEF in cycle 4.
REQ-039 IF and DM load (0x10008000) raised in same cycle -> DM done cycle 4, IF mem_en_o cycle 6, IF done cycle 9; stall_o high cycles 0-3 and 5-8.
REQ-040 DM store 0x12345678 to 0x10008004 -> mem_en_o=1, mem_we_o=1, mem_addr_o=0x4002001 in cycle 1; dm_ready_o cycle 4; dm_rdata_o unchanged.
REQ-041 rst_i pulsed in WAIT -> IDLE next cycle, no ready pulse, if_rdata_o=0x00000013; re-request completes normally.
REQ-042 LATENCY=1 and LATENCY=7 back-to-back IF loads -> ready in cycles 3 and 9 respectively; exactly one mem_en_o per request.
REQ-043 Random IF/DM traffic vs. reference memory model -> every completion data-correct, never two accesses in flight.
